// File: rtl/perceptron_scorer_if.sv
// Scorer bus: classifier sample inputs, clear/enable and readout.
// master drives samples and sel; slave is the scorer.
interface perceptron_scorer_if #(
  parameter int CNT_W = 8
);
  logic             ena;
  logic             sample_stb;
  logic             pred;
  logic             label;
  logic             clear;
  logic [1:0]       sel;
  logic [CNT_W-1:0] count_out;
  logic             batch_done;
  logic             pass;

  modport master (
    output ena, sample_stb, pred, label, clear, sel,
    input  count_out, batch_done, pass
  );

  modport slave (
    input  ena, sample_stb, pred, label, clear, sel,
    output count_out, batch_done, pass
  );
endinterface

// File: rtl/perceptron_scorer.sv
// Confusion-matrix scorer: syncs async sample_stb, counts TP/TN/FP/FN
// per batch, flags batch_done and pass. Ports: clk, rst_n, bus (slave).
module perceptron_scorer #(
  parameter int CNT_W            = 8,
  parameter int BATCH            = 16,
  parameter int PASS_MIN_CORRECT = 12,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  perceptron_scorer_if.slave  bus
);
  localparam int TOT_W = $clog2(BATCH + 1);
  localparam logic [TOT_W-1:0] BATCH_V = TOT_W'(BATCH);
  localparam logic [CNT_W:0]   PASS_V  = (CNT_W+1)'(PASS_MIN_CORRECT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic [CNT_W-1:0]       tp_q, tn_q, fp_q, fn_q;
  logic [CNT_W-1:0]       tp_d, tn_d, fp_d, fn_d;
  logic [TOT_W-1:0]       tot_q, tot_d;
  state_t                 state_q, state_d;
  logic                   pass_q, pass_d;
  logic                   done_q, done_d;
  logic                   stb_pulse;
  logic                   accept;
  logic [CNT_W:0]         correct;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  // Edge detect runs off the synchronized strobe, independent of ena.
  assign stb_pulse = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign accept = stb_pulse & bus.ena & ~bus.clear
                & (state_q != DONE);

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.sample_stb};
    dly_d   = sync_q[SYNC_STAGES-1];
    tp_d    = tp_q;
    tn_d    = tn_q;
    fp_d    = fp_q;
    fn_d    = fn_q;
    tot_d   = tot_q;
    state_d = state_q;
    pass_d  = pass_q;
    if (bus.ena && bus.clear) begin
      tp_d    = '0;
      tn_d    = '0;
      fp_d    = '0;
      fn_d    = '0;
      tot_d   = '0;
      state_d = IDLE;
      pass_d  = 1'b0;
    end else if (accept) begin
      unique case (1'b1)
        bus.pred & bus.label:   tp_d = sat_inc(tp_q);
        ~bus.pred & ~bus.label: tn_d = sat_inc(tn_q);
        bus.pred & ~bus.label:  fp_d = sat_inc(fp_q);
        default:                fn_d = sat_inc(fn_q);
      endcase
      tot_d = tot_q + 1'b1;
      if (tot_d == BATCH_V) begin
        state_d = DONE;
        pass_d  = correct >= PASS_V;
      end else begin
        state_d = ACCUM;
      end
    end
    done_d = (state_d == DONE);
  end

  // Includes the sample being accepted this cycle.
  assign correct = {1'b0, tp_d} + {1'b0, tn_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      dly_q   <= 1'b0;
      tp_q    <= '0;
      tn_q    <= '0;
      fp_q    <= '0;
      fn_q    <= '0;
      tot_q   <= '0;
      state_q <= IDLE;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      dly_q   <= dly_d;
      tp_q    <= tp_d;
      tn_q    <= tn_d;
      fp_q    <= fp_d;
      fn_q    <= fn_d;
      tot_q   <= tot_d;
      state_q <= state_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    unique case (bus.sel)
      2'b00:   bus.count_out = tp_q;
      2'b01:   bus.count_out = tn_q;
      2'b10:   bus.count_out = fp_q;
      default: bus.count_out = fn_q;
    endcase
  end

  assign bus.batch_done = done_q;
  assign bus.pass       = pass_q;
endmodule

// File: tb/tb_perceptron_scorer.sv
// Self-checking bench for perceptron_scorer against a counting model.
// Drives on negedge, reads outputs between edges.
module tb_perceptron_scorer;
  localparam int CNT_W = 8;
  localparam int BATCH = 16;
  localparam int PMIN  = 12;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  int   mc[4];
  int   mtot;
  bit   mdone;
  bit   mpass;

  perceptron_scorer_if #(.CNT_W(CNT_W)) bus ();

  perceptron_scorer #(
    .CNT_W(CNT_W),
    .BATCH(BATCH),
    .PASS_MIN_CORRECT(PMIN),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 4; i++) mc[i] = 0;
    mtot  = 0;
    mdone = 0;
    mpass = 0;
  endtask

  task automatic m_sample(bit p, bit l);
    int idx;
    if (mdone) return;
    if (p && l)        idx = 0;
    else if (!p && !l) idx = 1;
    else if (p)        idx = 2;
    else               idx = 3;
    if (mc[idx] < (1 << CNT_W) - 1) mc[idx]++;
    mtot++;
    if (mtot == BATCH) begin
      mdone = 1;
      mpass = (mc[0] + mc[1]) >= PMIN;
    end
  endtask

  task automatic check_all(string tag);
    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      #1;
      chk($sformatf("%s_sel%0d", tag, s), int'(bus.count_out), mc[s]);
    end
    chk({tag, "_done"}, int'(bus.batch_done), int'(mdone));
    chk({tag, "_pass"}, int'(bus.pass), int'(mpass));
  endtask

  // One strobe; clr/en are applied only during the pulse cycle.
  task automatic strobe(bit p, bit l, bit clr = 0, bit en = 1);
    @(negedge clk);
    bus.pred = p;
    bus.label = l;
    bus.sample_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.clear = clr;
    bus.ena = en;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.ena = 1'b1;
    @(negedge clk);
    bus.sample_stb = 1'b0;
    repeat (3) @(negedge clk);
    if (en && clr) m_clear();
    else if (en) m_sample(p, l);
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    m_clear();
  endtask

  initial begin
    bit p;
    bit l;
    int cnt;
    tests = 0;
    fails = 0;
    m_clear();
    rst_n = 1'b0;
    bus.ena = 1'b1;
    bus.sample_stb = 1'b0;
    bus.pred = 1'b0;
    bus.label = 1'b0;
    bus.clear = 1'b0;
    bus.sel = 2'b00;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // 1: strobes then async reset between clocks
    for (int i = 0; i < 5; i++) strobe(1'($urandom), 1'($urandom));
    check_all("t1_pre");
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_clear();
    check_all("t1_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 2: one of each class
    strobe(1, 1);
    strobe(0, 0);
    strobe(1, 0);
    strobe(0, 1);
    check_all("t2");

    // 3: 12 correct, 4 wrong, then an ignored 17th
    do_clear();
    for (int i = 0; i < 16; i++) begin
      p = 1'($urandom);
      l = (i < 12) ? p : ~p;
      strobe(p, l);
    end
    check_all("t3");
    strobe(1, 1);
    check_all("t3_17th");

    // 4: 11 correct, 5 wrong, then clear
    do_clear();
    for (int i = 0; i < 16; i++) begin
      p = 1'($urandom);
      l = (i < 11) ? p : ~p;
      strobe(p, l);
    end
    check_all("t4");
    do_clear();
    check_all("t4_clr");
    strobe(1, 1);
    check_all("t4_idle");

    // 5: latency and single pulse on a long strobe
    do_clear();
    @(negedge clk);
    bus.pred = 1'b1;
    bus.label = 1'b1;
    bus.sample_stb = 1'b1;
    bus.sel = 2'b00;
    @(posedge clk);
    #1 chk("t5_k", int'(bus.count_out), 0);
    @(posedge clk);
    #1 chk("t5_k1", int'(bus.count_out), 0);
    @(posedge clk);
    #1 chk("t5_k2", int'(bus.count_out), 1);
    repeat (8) @(posedge clk);
    #1 chk("t5_hold", int'(bus.count_out), 1);
    @(negedge clk);
    bus.sample_stb = 1'b0;
    repeat (3) @(negedge clk);
    m_sample(1, 1);
    check_all("t5");

    // 6: clear wins over pulse; ena=0 drops pulse and holds
    strobe(0, 0, 1, 1);
    check_all("t6_clr");
    strobe(1, 0);
    strobe(0, 1, 0, 0);
    check_all("t6_ena");
    @(negedge clk);
    bus.ena = 1'b0;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.ena = 1'b1;
    bus.clear = 1'b0;
    check_all("t6_hold");

    // random full batch
    do_clear();
    cnt = 0;
    while (!mdone && cnt < 40) begin
      strobe(1'($urandom), 1'($urandom));
      cnt++;
    end
    check_all("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
